// File: rtl/hello_stream_checker.sv
// Receiver-side checker for the scrolling HELLO stream: tracks H E L L O + blank gap
// frames, pulses o_match per good frame, and keeps saturating match/error counters.
module hello_stream_checker #(
  parameter int BLANK_RUN = 3,
  parameter int COUNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [2:0]         i_code,
  output logic               o_match,
  output logic               o_locked,
  output logic [COUNT_W-1:0] o_match_count,
  output logic [COUNT_W-1:0] o_err_count
);

  localparam logic [2:0] C_H     = 3'b000;
  localparam logic [2:0] C_E     = 3'b001;
  localparam logic [2:0] C_L     = 3'b010;
  localparam logic [2:0] C_O     = 3'b011;
  localparam logic [2:0] C_BLANK = 3'b111;
  localparam logic [2:0] GAP_MAX = 3'(BLANK_RUN);

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    GOT_H  = 3'd1,
    GOT_E  = 3'd2,
    GOT_L1 = 3'd3,
    GOT_L2 = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_gap_cnt;
  logic [2:0]          w_next_gap;
  logic                w_match_evt;
  logic                w_err_evt;
  logic                r_match;
  logic                r_locked;
  logic [COUNT_W-1:0]  r_match_cnt;
  logic [COUNT_W-1:0]  r_err_cnt;

  always_comb begin
    w_next_state = r_state;
    w_next_gap   = r_gap_cnt;
    w_match_evt  = 1'b0;
    w_err_evt    = 1'b0;
    if (i_enable) begin
      unique case (r_state)
        HUNT: begin
          if (i_code == C_H) w_next_state = GOT_H;
        end
        GOT_H: begin
          if (i_code == C_E) w_next_state = GOT_E;
          else               w_err_evt    = 1'b1;
        end
        GOT_E: begin
          if (i_code == C_L) w_next_state = GOT_L1;
          else               w_err_evt    = 1'b1;
        end
        GOT_L1: begin
          if (i_code == C_L) w_next_state = GOT_L2;
          else               w_err_evt    = 1'b1;
        end
        GOT_L2: begin
          if (i_code == C_O) begin
            w_next_state = GAP;
            w_next_gap   = 3'd0;
            w_match_evt  = 1'b1;
          end else begin
            w_err_evt = 1'b1;
          end
        end
        GAP: begin
          if (i_code == C_BLANK && r_gap_cnt < GAP_MAX) begin
            w_next_gap = r_gap_cnt + 3'd1;
          end else if (i_code == C_H && r_gap_cnt == GAP_MAX) begin
            w_next_state = GOT_H;
            w_next_gap   = 3'd0;
          end else begin
            w_err_evt = 1'b1;
          end
        end
        default: w_next_state = HUNT;
      endcase
      // An offending H is treated as the start of a fresh frame
      if (w_err_evt) begin
        w_next_state = (i_code == C_H) ? GOT_H : HUNT;
        w_next_gap   = 3'd0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= HUNT;
      r_gap_cnt <= 3'd0;
    end else begin
      r_state   <= w_next_state;
      r_gap_cnt <= w_next_gap;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_match     <= 1'b0;
      r_locked    <= 1'b0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_match <= w_match_evt;
      if (w_match_evt) begin
        r_locked <= 1'b1;
        if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + COUNT_W'(1);
      end
      if (w_err_evt) begin
        r_locked <= 1'b0;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + COUNT_W'(1);
      end
    end
  end

  assign o_match       = r_match;
  assign o_locked      = r_locked;
  assign o_match_count = r_match_cnt;
  assign o_err_count   = r_err_cnt;

endmodule

// File: tb/tb_hello_stream_checker.sv
// Bench for hello_stream_checker: frame-position reference model, vector table,
// directed corner sequences and random stimulus on an 8-bit and a 2-bit-counter DUT.
module tb_hello_stream_checker;

  localparam int BR   = 3;
  localparam int FLEN = 5 + BR;
  localparam logic [2:0] H = 3'b000, E = 3'b001, L = 3'b010, O = 3'b011, B = 3'b111;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_enable = 1'b0;
  logic [2:0] i_code = 3'b000;
  logic       o_match, o_locked;
  logic [7:0] o_match_count, o_err_count;
  logic       s_match, s_locked;
  logic [1:0] s_match_count, s_err_count;

  int total = 0;
  int bad = 0;

  // model: m_pos = -1 while hunting, else number of frame symbols matched (1..FLEN)
  int m_pos, m_mcnt, m_ecnt;
  bit m_match, m_locked;

  always #5 i_clk = ~i_clk;

  hello_stream_checker #(.BLANK_RUN(BR), .COUNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_code(i_code),
    .o_match(o_match), .o_locked(o_locked),
    .o_match_count(o_match_count), .o_err_count(o_err_count));

  hello_stream_checker #(.BLANK_RUN(BR), .COUNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_code(i_code),
    .o_match(s_match), .o_locked(s_locked),
    .o_match_count(s_match_count), .o_err_count(s_err_count));

  function automatic logic [2:0] frame_code(input int idx);
    case (idx)
      0: return H;
      1: return E;
      2, 3: return L;
      4: return O;
      default: return B;
    endcase
  endfunction

  function automatic logic [2:0] model_expected();
    return (m_pos < 0) ? H : frame_code(m_pos % FLEN);
  endfunction

  function automatic void model_reset();
    m_pos = -1; m_mcnt = 0; m_ecnt = 0; m_match = 0; m_locked = 0;
  endfunction

  function automatic void model_step(input bit en, input logic [2:0] c);
    m_match = 0;
    if (!en) return;
    if (m_pos < 0) begin
      if (c == H) m_pos = 1;
    end else if (c == frame_code(m_pos % FLEN)) begin
      m_pos = (m_pos % FLEN) + 1;
      if (m_pos == 5) begin
        m_match = 1; m_locked = 1; m_mcnt++;
      end
    end else begin
      m_ecnt++; m_locked = 0;
      m_pos = (c == H) ? 1 : -1;
    end
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("match",       int'(o_match),       int'(m_match));
    chk("locked",      int'(o_locked),      int'(m_locked));
    chk("match_count", int'(o_match_count), sat(m_mcnt, 255));
    chk("err_count",   int'(o_err_count),   sat(m_ecnt, 255));
    chk("sat_match",   int'(s_match),       int'(m_match));
    chk("sat_locked",  int'(s_locked),      int'(m_locked));
    chk("sat_mcount",  int'(s_match_count), sat(m_mcnt, 3));
    chk("sat_ecount",  int'(s_err_count),   sat(m_ecnt, 3));
  endtask

  task automatic tick(input bit en, input logic [2:0] c);
    i_enable = en;
    i_code   = c;
    @(posedge i_clk);
    model_step(en, c);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    i_enable = 0;
    i_rst = 1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 0;
    model_reset();
    check_model();
  endtask

  task automatic send_frame();
    tick(1, H); tick(1, E); tick(1, L); tick(1, L); tick(1, O);
    for (int k = 0; k < BR; k++) tick(1, B);
  endtask

  typedef struct {
    bit         en;
    logic [2:0] code;
    bit         m;
    bit         lk;
    int         mc;
    int         ec;
  } vec_t;

  vec_t vecs[13];
  int   pulses;

  initial begin
    vecs[0]  = '{1'b1, H, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, E, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b1, L, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, E, 1'b0, 1'b0, 0, 1};
    vecs[4]  = '{1'b1, E, 1'b0, 1'b0, 0, 1};
    vecs[5]  = '{1'b1, H, 1'b0, 1'b0, 0, 1};
    vecs[6]  = '{1'b1, E, 1'b0, 1'b0, 0, 1};
    vecs[7]  = '{1'b0, B, 1'b0, 1'b0, 0, 1};
    vecs[8]  = '{1'b1, L, 1'b0, 1'b0, 0, 1};
    vecs[9]  = '{1'b1, L, 1'b0, 1'b0, 0, 1};
    vecs[10] = '{1'b1, O, 1'b1, 1'b1, 1, 1};
    vecs[11] = '{1'b0, O, 1'b0, 1'b1, 1, 1};
    vecs[12] = '{1'b1, B, 1'b0, 1'b1, 1, 1};

    model_reset();
    do_reset();

    // Two clean frames, one strobe every 4 cycles
    pulses = 0;
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < FLEN; s++) begin
        tick(1, frame_code(s));
        if (o_match) pulses++;
        for (int g = 0; g < 3; g++) begin
          tick(0, B);
          if (o_match) pulses++;
        end
      end
    end
    chk("slow_pulses", pulses, 2);
    chk("slow_mcount", int'(o_match_count), 2);
    chk("slow_locked", int'(o_locked), 1);

    // Wrong fourth letter, then a clean frame (table)
    do_reset();
    foreach (vecs[i]) begin
      tick(vecs[i].en, vecs[i].code);
      chk("tbl_match",  int'(o_match),       int'(vecs[i].m));
      chk("tbl_locked", int'(o_locked),      int'(vecs[i].lk));
      chk("tbl_mcount", int'(o_match_count), vecs[i].mc);
      chk("tbl_ecount", int'(o_err_count),   vecs[i].ec);
    end

    // Short gap: H after two blanks resyncs into a frame
    do_reset();
    send_frame();
    do_reset();
    tick(1, H); tick(1, E); tick(1, L); tick(1, L); tick(1, O);
    tick(1, B); tick(1, B); tick(1, H);
    chk("short_gap_err",    int'(o_err_count), 1);
    chk("short_gap_locked", int'(o_locked), 0);
    tick(1, E); tick(1, L); tick(1, L); tick(1, O);
    chk("resync_match",  int'(o_match), 1);
    chk("resync_mcount", int'(o_match_count), 2);
    chk("resync_locked", int'(o_locked), 1);

    // Long gap: fourth blank errors and drops to hunt
    do_reset();
    tick(1, H); tick(1, E); tick(1, L); tick(1, L); tick(1, O);
    for (int k = 0; k < BR; k++) tick(1, B);
    chk("gap_full_no_err", int'(o_err_count), 0);
    tick(1, B);
    chk("long_gap_err", int'(o_err_count), 1);
    tick(1, E); tick(1, O);
    chk("hunt_after_long_gap", int'(o_err_count), 1);

    // Illegal code ignored while hunting, counted mid-frame
    do_reset();
    tick(1, 3'b101);
    chk("illegal_hunt", int'(o_err_count), 0);
    tick(1, H); tick(1, E); tick(1, 3'b101);
    chk("illegal_got_e", int'(o_err_count), 1);

    // Saturation on the 2-bit instance
    do_reset();
    for (int f = 0; f < 5; f++) send_frame();
    chk("sat_hold", int'(s_match_count), 3);
    chk("full_five", int'(o_match_count), 5);

    // Async reset mid-frame
    tick(1, H); tick(1, E);
    #2;
    i_rst = 1;
    #1;
    chk("arst_locked", int'(o_locked), 0);
    chk("arst_mcount", int'(o_match_count), 0);
    chk("arst_sat_mcount", int'(s_match_count), 0);
    @(posedge i_clk);
    #1;
    i_rst = 0;
    model_reset();
    tick(1, L); tick(1, L); tick(1, O); tick(0, B);
    chk("arst_no_match", int'(o_match_count), 0);

    // Random stimulus biased toward legal frames
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] c;
      bit en;
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7) c = model_expected();
      else                          c = 3'($urandom_range(0, 7));
      tick(en, c);
      if (n == 700) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
